keypad_entry: RTL and testbench

Input-side counterpart to the team's seven-segment display driver. It scans a 4x4 hex keypad (Pmod KYPD) by driving columns and reading rows, and debounces each key. Each new key press is reported as a one-cycle strobe and shifted into a 16-bit entry register. That register is sized to feed the display's 16-bit data input, so operators can type hex values for the RAT MCU.

---
 rtl/keypad_entry.sv | 218 +++++++++++++++++++++
 tb/tb_keypad_entry.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_entry.sv
// keypad_entry: scans a 4x4 hex keypad (Pmod KYPD) one column at a time and
// debounces whole-keypad scans. Each newly accepted key is reported with a
// one-cycle strobe and shifted into a 16-bit entry register (newest nibble low).
module keypad_entry #(
    parameter int SCAN_DIV       = 100000,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic [3:0]  i_rows,
    input  logic        i_clr,
    output logic [3:0]  o_cols,
    output logic        o_key_valid,
    output logic [3:0]  o_key_code,
    output logic [15:0] o_data_out
);

    localparam int PER_W  = $clog2(SCAN_DIV);
    localparam int STAB_W = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [PER_W-1:0]  PER_LAST = PER_W'(SCAN_DIV - 1);
    localparam logic [STAB_W-1:0] STAB_MAX = STAB_W'(DEBOUNCE_SCANS);
    localparam logic [STAB_W-1:0] STAB_ONE = STAB_W'(1);
    // Candidate encoding: {valid, code}; all-zero means NONE.
    localparam logic [4:0] CAND_NONE = 5'b0_0000;

    typedef enum logic {
        ST_RELEASED = 1'b0,
        ST_HELD     = 1'b1
    } state_t;

    // Hex legend of the keypad, row r / column c.
    function automatic logic [3:0] key_code(input logic [1:0] row, input logic [1:0] col);
        logic [3:0] code;
        case ({row, col})
            4'b00_00: code = 4'h1;
            4'b00_01: code = 4'h2;
            4'b00_10: code = 4'h3;
            4'b00_11: code = 4'hA;
            4'b01_00: code = 4'h4;
            4'b01_01: code = 4'h5;
            4'b01_10: code = 4'h6;
            4'b01_11: code = 4'hB;
            4'b10_00: code = 4'h7;
            4'b10_01: code = 4'h8;
            4'b10_10: code = 4'h9;
            4'b10_11: code = 4'hC;
            4'b11_00: code = 4'h0;
            4'b11_01: code = 4'hF;
            4'b11_10: code = 4'hE;
            4'b11_11: code = 4'hD;
            default:  code = 4'h0;
        endcase
        return code;
    endfunction

    logic [3:0]        r_rows_meta;
    logic [3:0]        r_rows_sync;
    logic [PER_W-1:0]  r_period;
    logic [1:0]        r_col;
    logic [3:0]        r_cols;
    logic [1:0]        r_acc_cnt;    // keys seen so far this scan, 2 means "many"
    logic [3:0]        r_acc_code;
    logic              r_scan_done;
    logic [4:0]        r_scan_cand;
    logic [4:0]        r_prev_cand;
    logic [STAB_W-1:0] r_stab;
    state_t            r_state;
    logic              r_key_valid;
    logic [3:0]        r_key_code;
    logic [15:0]       r_data;

    logic              w_sample;
    logic [2:0]        w_col_cnt;
    logic [3:0]        w_col_code;
    logic [2:0]        w_sum;
    logic [1:0]        w_merge_cnt;
    logic [3:0]        w_merge_code;
    logic [4:0]        w_scan_cand;
    logic [STAB_W-1:0] w_stab_next;
    logic              w_stable;
    logic              w_accept;
    logic              w_release;

    assign w_sample = (r_period == PER_LAST);

    // Two-flop synchronizer for the asynchronous, pulled-up row inputs.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rows_meta <= 4'hF;
            r_rows_sync <= 4'hF;
        end else begin
            r_rows_meta <= i_rows;
            r_rows_sync <= r_rows_meta;
        end
    end

    // Decode the rows of the currently driven column and fold them into the scan.
    always_comb begin
        w_col_cnt  = 3'd0;
        w_col_code = 4'h0;
        for (int r = 0; r < 4; r++) begin
            if (!r_rows_sync[r]) begin
                w_col_cnt  = w_col_cnt + 3'd1;
                w_col_code = key_code(2'(r), r_col);
            end else begin
                w_col_cnt  = w_col_cnt;
            end
        end
        w_sum        = {1'b0, r_acc_cnt} + w_col_cnt;
        w_merge_cnt  = (w_sum >= 3'd2) ? 2'd2 : w_sum[1:0];
        w_merge_code = (r_acc_cnt == 2'd0) ? w_col_code : r_acc_code;
        w_scan_cand  = (w_merge_cnt == 2'd1) ? {1'b1, w_merge_code} : CAND_NONE;
    end

    // Column scan: period/column counters, column drive and per-scan accumulation.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_period    <= '0;
            r_col       <= 2'd0;
            r_cols      <= 4'b1110;
            r_acc_cnt   <= 2'd0;
            r_acc_code  <= 4'h0;
            r_scan_done <= 1'b0;
            r_scan_cand <= CAND_NONE;
        end else if (w_sample) begin
            r_period <= '0;
            r_col    <= r_col + 2'd1;
            r_cols   <= {r_cols[2:0], r_cols[3]};
            if (r_col == 2'd3) begin
                r_acc_cnt   <= 2'd0;
                r_acc_code  <= 4'h0;
                r_scan_cand <= w_scan_cand;
                r_scan_done <= 1'b1;
            end else begin
                r_acc_cnt   <= w_merge_cnt;
                r_acc_code  <= w_merge_code;
                r_scan_done <= 1'b0;
            end
        end else begin
            r_period    <= r_period + {{(PER_W-1){1'b0}}, 1'b1};
            r_scan_done <= 1'b0;
        end
    end

    // Stability count after this scan, and the press/release decisions it allows.
    always_comb begin
        if (r_scan_cand != r_prev_cand) begin
            w_stab_next = STAB_ONE;
        end else if (r_stab == STAB_MAX) begin
            w_stab_next = STAB_MAX;
        end else begin
            w_stab_next = r_stab + STAB_ONE;
        end
        w_stable  = (w_stab_next == STAB_MAX);
        w_accept  = r_scan_done && (r_state == ST_RELEASED) && r_scan_cand[4] && w_stable;
        w_release = r_scan_done && (r_state == ST_HELD) && !r_scan_cand[4] && w_stable;
    end

    // Debounce FSM with registered strobe, key code and entry shift register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= ST_RELEASED;
            r_prev_cand <= CAND_NONE;
            r_stab      <= '0;
            r_key_valid <= 1'b0;
            r_key_code  <= 4'h0;
            r_data      <= 16'h0000;
        end else begin
            if (r_scan_done) begin
                r_prev_cand <= r_scan_cand;
                r_stab      <= w_stab_next;
            end else begin
                r_prev_cand <= r_prev_cand;
                r_stab      <= r_stab;
            end

            case (r_state)
                ST_RELEASED: begin
                    if (w_accept) begin
                        r_state <= ST_HELD;
                    end else begin
                        r_state <= ST_RELEASED;
                    end
                end
                ST_HELD: begin
                    if (w_release) begin
                        r_state <= ST_RELEASED;
                    end else begin
                        r_state <= ST_HELD;
                    end
                end
                default: r_state <= ST_RELEASED;
            endcase

            r_key_valid <= w_accept;
            if (w_accept) begin
                r_key_code <= r_scan_cand[3:0];
            end else begin
                r_key_code <= r_key_code;
            end

            // Clear takes priority over a simultaneous accept.
            if (i_clr) begin
                r_data <= 16'h0000;
            end else if (w_accept) begin
                r_data <= {r_data[11:0], r_scan_cand[3:0]};
            end else begin
                r_data <= r_data;
            end
        end
    end

    assign o_cols      = r_cols;
    assign o_key_valid = r_key_valid;
    assign o_key_code  = r_key_code;
    assign o_data_out  = r_data;

endmodule

// File: tb/tb_keypad_entry.sv
// Testbench for keypad_entry: a keypad model pulls rows low for pressed keys in
// the driven column; a scan-level reference model predicts strobes and outputs.
module tb_keypad_entry;

    localparam int SD = 4;
    localparam int DS = 2;
    localparam int SCAN_CYC = 4 * SD;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        clr;
    logic [3:0]  rows;
    logic [3:0]  cols;
    logic        key_valid;
    logic [3:0]  key_code;
    logic [15:0] data_out;
    logic [15:0] pressed;

    int n_vec = 0;
    int n_err = 0;
    int strobes = 0;

    // Reference model state
    int          hist[$];
    int          m_held;
    logic [3:0]  m_code;
    logic [15:0] m_data;
    int          pending;

    logic [3:0] keymap [16] = '{4'h1, 4'h2, 4'h3, 4'hA,
                                4'h4, 4'h5, 4'h6, 4'hB,
                                4'h7, 4'h8, 4'h9, 4'hC,
                                4'h0, 4'hF, 4'hE, 4'hD};

    keypad_entry #(.SCAN_DIV(SD), .DEBOUNCE_SCANS(DS)) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_rows      (rows),
        .i_clr       (clr),
        .o_cols      (cols),
        .o_key_valid (key_valid),
        .o_key_code  (key_code),
        .o_data_out  (data_out)
    );

    always #5 clk = ~clk;

    // Physical keypad: a pressed key shorts its row to its column when driven low.
    always_comb begin
        rows = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (pressed[r*4+c] && !cols[c]) rows[r] = 1'b0;
    end

    function automatic int cand_of(input logic [15:0] m);
        if ($countones(m) != 1) return -1;
        for (int i = 0; i < 16; i++) if (m[i]) return int'(keymap[i]);
        return -1;
    endfunction

    function automatic logic [15:0] kmask(input logic [3:0] code);
        logic [15:0] one;
        one = 16'h0001;
        for (int i = 0; i < 16; i++) if (keymap[i] == code) return one << i;
        return 16'h0000;
    endfunction

    task automatic model_reset();
        hist.delete();
        m_held = 0; m_code = 4'h0; m_data = 16'h0000; pending = 0;
    endtask

    // One full scan (16 cycles) with a fixed set of pressed keys.
    task automatic run_scan(input logic [15:0] m, input logic do_clr);
        logic       exp_valid;
        logic [3:0] exp_cols;
        logic [3:0] one;
        int         c;
        int         stable;
        one = 4'b0001;
        pressed = m;
        clr = do_clr;
        for (int i = 1; i <= SCAN_CYC; i++) begin
            @(posedge clk); #1;
            if (i == 1) begin
                clr = 1'b0;
                if (do_clr) m_data = 16'h0000;
            end
            exp_valid = (i == 1) && (pending != 0);
            n_vec++;
            if (key_valid !== exp_valid) begin
                n_err++;
                $display("FAIL key_valid cyc%0d: got %b expected %b", i, key_valid, exp_valid);
            end
            if (key_valid === 1'b1) strobes++;
            exp_cols = ~(one << ((i / SD) % 4));
            n_vec++;
            if (cols !== exp_cols) begin
                n_err++;
                $display("FAIL cols cyc%0d: got %b expected %b", i, cols, exp_cols);
            end
            if (i == SCAN_CYC) begin
                n_vec++;
                if (key_code !== m_code) begin
                    n_err++;
                    $display("FAIL key_code: got %h expected %h", key_code, m_code);
                end
                n_vec++;
                if (data_out !== m_data) begin
                    n_err++;
                    $display("FAIL data_out: got %h expected %h", data_out, m_data);
                end
            end
        end
        // A decision is stable when the last DS scans agree.
        pending = 0;
        c = cand_of(m);
        hist.push_back(c);
        while (hist.size() > DS) void'(hist.pop_front());
        stable = (hist.size() >= DS);
        foreach (hist[k]) if (hist[k] != c) stable = 0;
        if (m_held == 0 && c >= 0 && stable != 0) begin
            pending = 1; m_held = 1;
            m_code = 4'(c);
            m_data = {m_data[11:0], 4'(c)};
        end else if (m_held != 0 && c < 0 && stable != 0) begin
            m_held = 0;
        end
    endtask

    task automatic check_val(input string name, input logic [15:0] got, input logic [15:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic test_reset();
        pressed = 16'h0000; clr = 1'b0; rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_vec++;
        if (cols !== 4'b1110 || key_valid !== 1'b0 || key_code !== 4'h0 || data_out !== 16'h0000) begin
            n_err++;
            $display("FAIL reset_values: got %b %b %h %h expected 1110 0 0 0000", cols, key_valid, key_code, data_out);
        end
        @(negedge clk); rst_n = 1'b1;
        model_reset();
        strobes = 0;
        repeat (4) run_scan(16'h0000, 1'b0);
        check_val("reset_strobes", 16'(strobes), 16'd0);
    endtask

    task automatic test_single_press();
        strobes = 0;
        repeat (5) run_scan(kmask(4'h5), 1'b0);
        repeat (3) run_scan(16'h0000, 1'b0);
        check_val("single_strobes", 16'(strobes), 16'd1);
        check_val("single_code", {12'h000, key_code}, 16'h0005);
        check_val("single_data", data_out, 16'h0005);
    endtask

    task automatic test_entry_sequence();
        logic [3:0] seq [5];
        seq = '{4'h1, 4'hA, 4'h0, 4'hF, 4'hD};
        strobes = 0;
        foreach (seq[k]) begin
            repeat (3) run_scan(kmask(seq[k]), 1'b0);
            repeat (3) run_scan(16'h0000, 1'b0);
        end
        check_val("entry_strobes", 16'(strobes), 16'd5);
        check_val("entry_data", data_out, 16'hA0FD);
    endtask

    task automatic test_bounce();
        strobes = 0;
        run_scan(kmask(4'h9), 1'b0);
        run_scan(16'h0000, 1'b0);
        run_scan(kmask(4'h9), 1'b0);
        check_val("bounce_early", 16'(strobes), 16'd0);
        repeat (3) run_scan(kmask(4'h9), 1'b0);
        repeat (3) run_scan(16'h0000, 1'b0);
        check_val("bounce_strobes", 16'(strobes), 16'd1);
        check_val("bounce_code", {12'h000, key_code}, 16'h0009);
    endtask

    task automatic test_ghost();
        strobes = 0;
        repeat (6) run_scan(kmask(4'h2) | kmask(4'h6), 1'b0);
        check_val("ghost_none", 16'(strobes), 16'd0);
        repeat (3) run_scan(kmask(4'h2), 1'b0);
        repeat (3) run_scan(16'h0000, 1'b0);
        check_val("ghost_strobes", 16'(strobes), 16'd1);
        check_val("ghost_code", {12'h000, key_code}, 16'h0002);
    endtask

    task automatic test_clr_collision();
        repeat (2) run_scan(kmask(4'h7), 1'b0);
        run_scan(kmask(4'h7), 1'b1);
        check_val("clr_code", {12'h000, key_code}, 16'h0007);
        check_val("clr_data", data_out, 16'h0000);
        repeat (3) run_scan(16'h0000, 1'b0);
    endtask

    task automatic test_reset_midpress();
        repeat (2) run_scan(kmask(4'h3), 1'b0);
        repeat (3) run_scan(16'h0000, 1'b0);
        check_val("pre_reset_data", data_out, 16'h0003);
        run_scan(kmask(4'h8), 1'b0);
        repeat (5) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check_val("async_cols", {12'h000, cols}, 16'h000E);
        check_val("async_valid", {15'h0000, key_valid}, 16'h0000);
        check_val("async_code", {12'h000, key_code}, 16'h0000);
        check_val("async_data", data_out, 16'h0000);
        pressed = 16'h0000;
        repeat (2) @(posedge clk);
        @(negedge clk); rst_n = 1'b1;
        model_reset();
        strobes = 0;
        repeat (3) run_scan(16'h0000, 1'b0);
        check_val("reset_no_strobe", 16'(strobes), 16'd0);
    endtask

    task automatic test_random();
        logic [15:0] one;
        logic [15:0] m;
        int kind, a, b, dur;
        one = 16'h0001;
        for (int s = 0; s < 30; s++) begin
            kind = $urandom_range(0, 3);
            a = $urandom_range(0, 15);
            b = (a + $urandom_range(1, 15)) % 16;
            if (kind == 0) m = 16'h0000;
            else if (kind == 3) m = (one << a) | (one << b);
            else m = one << a;
            dur = $urandom_range(1, 4);
            for (int d = 0; d < dur; d++)
                run_scan(m, (d == 0) && ($urandom_range(0, 7) == 0));
        end
        repeat (3) run_scan(16'h0000, 1'b0);
    endtask

    initial begin
        test_reset();
        test_single_press();
        test_entry_sequence();
        test_bounce();
        test_ghost();
        test_clr_collision();
        test_reset_midpress();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
